// File: rtl/sram_req_frontend.sv
// Valid/ready request/response front-end for a 1-cycle-read byte-masked SRAM macro.
// Optional macro SRAM_FRONTEND_WRACK_EN: writes take a credit and return a response flagged on rsp_we.
module sram_req_frontend #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WMASK_WIDTH = 8,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
`ifdef SRAM_FRONTEND_WRACK_EN
    output logic                   rsp_we,
`endif
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  mem_we_q;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n, rd_inc_c;
    logic [CNT_W-1:0]      count_q, count_n;
    logic                  inflight_q, inflight_n;
    logic                  inflight_we_q, inflight_we_n;
    logic                  ready_q, ready_n;
    logic                  valid_q, valid_n;
    logic [DATA_WIDTH-1:0] head_q, head_n;
    logic                  head_we_q, head_we_n;
    logic                  accept_c, credit_c, push_c, pop_c;
    logic [DATA_WIDTH-1:0] push_data_c;
    logic [OCC_W-1:0]      occ_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Macro pins are driven straight from the request port
    assign accept_c   = req_valid & ready_q;
    assign sram_we    = accept_c & req_we;
    assign sram_wmask = sram_we ? req_wmask : '0;
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;

`ifdef SRAM_FRONTEND_WRACK_EN
    assign credit_c = accept_c;
`else
    assign credit_c = accept_c & ~req_we;
`endif

    // Write responses carry zero data so a write-cycle dout never reaches the FIFO
    assign push_c      = inflight_q;
    assign push_data_c = inflight_we_q ? '0 : sram_dout;
    assign pop_c       = valid_q & rsp_ready;
    assign rd_inc_c    = ptr_inc(rd_ptr_q);

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = head_q;
`ifdef SRAM_FRONTEND_WRACK_EN
    assign rsp_we    = head_we_q;
`endif

    always_comb begin
        count_n       = count_q;
        rd_ptr_n      = rd_ptr_q;
        wr_ptr_n      = wr_ptr_q;
        head_n        = head_q;
        head_we_n     = head_we_q;
        inflight_n    = credit_c;
        inflight_we_n = credit_c & req_we;

        case ({push_c, pop_c})
            2'b10:   count_n = count_q + CNT_W'(1);
            2'b01:   count_n = count_q - CNT_W'(1);
            default: count_n = count_q;
        endcase
        if (pop_c)  rd_ptr_n = rd_inc_c;
        if (push_c) wr_ptr_n = ptr_inc(wr_ptr_q);

        // Registered head: pushed word when it becomes the head, else the next stored entry
        if (push_c && (count_q == '0 || (count_q == CNT_W'(1) && pop_c))) begin
            head_n    = push_data_c;
            head_we_n = inflight_we_q;
        end else if (pop_c && count_q >= CNT_W'(2)) begin
            head_n    = mem_q[rd_inc_c];
            head_we_n = mem_we_q[rd_inc_c];
        end

        occ_n   = OCC_W'(count_n) + OCC_W'(inflight_n);
        ready_n = (occ_n < OCC_W'(RSP_DEPTH));
        valid_n = (count_n != '0);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_we_q <= 1'b0;
            ready_q       <= 1'b0;
            valid_q       <= 1'b0;
            head_q        <= '0;
            head_we_q     <= 1'b0;
            mem_we_q      <= '0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_n;
            wr_ptr_q      <= wr_ptr_n;
            count_q       <= count_n;
            inflight_q    <= inflight_n;
            inflight_we_q <= inflight_we_n;
            ready_q       <= ready_n;
            valid_q       <= valid_n;
            head_q        <= head_n;
            head_we_q     <= head_we_n;
            if (push_c) begin
                mem_q[wr_ptr_q]    <= push_data_c;
                mem_we_q[wr_ptr_q] <= inflight_we_q;
            end
        end
    end

    // The credit rule must keep pushes away from a full FIFO that is not draining
    always_ff @(posedge clk) begin
        if (rstb) begin
            assert (!(push_c && !pop_c && count_q == CNT_W'(RSP_DEPTH)))
                else $error("sram_req_frontend: push into full response FIFO");
        end
    end

endmodule
